wb_regfile_sb: RTL and testbench

- Write-back stage and architectural register file. Sits directly downstream of the MEM_Out buffer.
- Consumes the 20-bit write-back packet: bit 19 = write enable, bits 18:16 = destination register, bits 15:0 = data.
- Supplies two bypassed read ports to decode.
- Holds a per-register pending-write scoreboard. Decode uses it to stall on RAW hazards until the producing instruction has written back.

---
 rtl/wb_regfile_sb_pkg.sv | 12 +
 rtl/wb_regfile_sb_counter.sv | 24 ++
 rtl/wb_regfile_sb.sv | 62 ++++++
 tb/tb_wb_regfile_sb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_sb_pkg.sv
// wb_regfile_sb_pkg: shared widths and write-back packet field positions.
package wb_regfile_sb_pkg;
  localparam int DW         = 16;
  localparam int AW         = 3;
  localparam int NREG       = 2 ** AW;
  localparam int CNTW       = 2;
  localparam int WB_WE_BIT  = 19;
  localparam int WB_RD_HI   = 18;
  localparam int WB_RD_LO   = 16;
  localparam int WB_DATA_HI = 15;
  localparam int WB_DATA_LO = 0;
endpackage

// File: rtl/wb_regfile_sb_counter.sv
// sb_counter: saturating pending-write counter; err_o strobes on overflow or underflow.
module sb_counter
  import wb_regfile_sb_pkg::*;
#(
  parameter int W = CNTW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic up, dn;
  assign up    = inc_i & ~dec_i;
  assign dn    = dec_i & ~inc_i;
  assign err_o = (up & (cnt_q == '1)) | (dn & (cnt_q == '0));
  assign cnt_d = err_o ? cnt_q : up ? cnt_q + W'(1) : dn ? cnt_q - W'(1) : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb: write-back stage, bypassed register file and RAW scoreboard.
// Define R0_ZERO_EN to hardwire register 0 to zero.
module wb_regfile_sb
  import wb_regfile_sb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_WE_BIT:0]     wb_packet,
  input  logic [AW-1:0]          rs1_addr,
  input  logic [AW-1:0]          rs2_addr,
  output logic [DW-1:0]          rs1_data,
  output logic [DW-1:0]          rs2_data,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [AW-1:0]          issue_rd,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   sb_err
);
`ifdef R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  logic            wb_we, wr_en, sb_err_q;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic [DW-1:0]   regs_q [NREG];
  logic [CNTW-1:0] cnt [NREG];
  logic [NREG-1:0] inc, dec, err;
  assign wb_we   = wb_packet[WB_WE_BIT];
  assign wb_rd   = wb_packet[WB_RD_HI:WB_RD_LO];
  assign wb_data = wb_packet[WB_DATA_HI:WB_DATA_LO];
  assign wr_en   = wb_we & ~(R0Z & (wb_rd == '0));
  for (genvar i = 0; i < NREG; i++) begin : g_sb
    assign inc[i] = (R0Z && i == 0) ? 1'b0 : issue_valid & issue_we & (issue_rd == AW'(i));
    assign dec[i] = (R0Z && i == 0) ? 1'b0 : wb_we & (wb_rd == AW'(i));
    sb_counter #(.W(CNTW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc[i]),
      .dec_i (dec[i]),
      .cnt_o (cnt[i]),
      .err_o (err[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      if (wr_en) regs_q[wb_rd] <= wb_data;
      sb_err_q <= sb_err_q | (|err);
    end
  // wr_en already excludes r0 when hardwired, so the bypass never forwards into it
  assign rs1_data = (R0Z && rs1_addr == '0) ? '0 : (wr_en && wb_rd == rs1_addr) ? wb_data : regs_q[rs1_addr];
  assign rs2_data = (R0Z && rs2_addr == '0) ? '0 : (wr_en && wb_rd == rs2_addr) ? wb_data : regs_q[rs2_addr];
  // a write-back retiring the last pending write clears the hazard in the same cycle
  assign rs1_busy = cnt[rs1_addr] > CNTW'(dec[rs1_addr]);
  assign rs2_busy = cnt[rs2_addr] > CNTW'(dec[rs2_addr]);
  assign sb_err   = sb_err_q;
endmodule

// File: tb/tb_wb_regfile_sb.sv
// tb_wb_regfile_sb: directed self-checking bench for wb_regfile_sb.
module tb_wb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] wb_packet;
  logic [2:0]  rs1_addr, rs2_addr, issue_rd;
  logic [15:0] rs1_data, rs2_data;
  logic        issue_valid, issue_we;
  logic        rs1_busy, rs2_busy, sb_err;
  int          checks = 0;
  int          errors = 0;

  wb_regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .wb_packet   (wb_packet),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_packet = '0; rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
    #12;
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_rs2_data", rs2_data, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_rs2_busy", rs2_busy, 0);
    chk("rst_sb_err", sb_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // write reg5 with bypass on port 2, stored value on port 1 next cycle
    wb_packet = {1'b1, 3'd5, 16'hABCD}; rs1_addr = 3'd5; rs2_addr = 3'd5;
    #1;
    chk("bypass_rs2_r5", rs2_data, 16'hABCD);
    chk("busy_rs1_r5_unissued", rs1_busy, 0);
    tick();
    wb_packet = '0;
    #1;
    chk("stored_rs1_r5", rs1_data, 16'hABCD);
    chk("underflow_err_r5", sb_err, 1);

    // pending write on r6, then asynchronous reset between edges
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 3'd6;
    tick();
    issue_valid = 1'b0; rs2_addr = 3'd6;
    #1;
    chk("busy_r6_pending", rs2_busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", rs2_busy, 0);
    chk("async_rst_err", sb_err, 0);
    chk("async_rst_r5", rs1_data, 0);
    #1 rst = 1'b0;
    tick();

    // RAW on r2 until its write-back arrives
    issue_valid = 1'b1; issue_rd = 3'd2;
    tick();
    issue_valid = 1'b0; rs1_addr = 3'd2;
    #1;
    chk("raw_r2_busy0", rs1_busy, 1);
    tick();
    chk("raw_r2_busy1", rs1_busy, 1);
    wb_packet = {1'b1, 3'd2, 16'h0042};
    #1;
    chk("raw_r2_wb_busy", rs1_busy, 0);
    chk("raw_r2_wb_data", rs1_data, 16'h0042);
    tick();
    wb_packet = '0;
    #1;
    chk("raw_r2_after_busy", rs1_busy, 0);
    chk("raw_r2_after_data", rs1_data, 16'h0042);
    chk("raw_r2_no_err", sb_err, 0);

    // saturate r3 at 3, overflow, then drain
    issue_valid = 1'b1; issue_rd = 3'd3; rs1_addr = 3'd3;
    tick(); tick(); tick();
    chk("sat_r3_no_err", sb_err, 0);
    chk("sat_r3_busy", rs1_busy, 1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sat_r3_overflow_err", sb_err, 1);
    wb_packet = {1'b1, 3'd3, 16'h0333};
    tick();
    chk("drain_r3_cnt2_busy", rs1_busy, 1);
    tick();
    chk("drain_r3_last_busy", rs1_busy, 0);
    chk("drain_r3_bypass", rs1_data, 16'h0333);
    tick();
    wb_packet = '0;
    #1;
    chk("drain_r3_idle_busy", rs1_busy, 0);
    chk("drain_r3_err_sticky", sb_err, 1);

    // underflow on r4 still writes the register
    rst = 1'b1; #2 rst = 1'b0;
    tick();
    wb_packet = {1'b1, 3'd4, 16'h1111}; rs1_addr = 3'd4;
    tick();
    wb_packet = '0;
    #1;
    chk("uf_r4_data", rs1_data, 16'h1111);
    chk("uf_r4_err", sb_err, 1);
    chk("uf_r4_busy", rs1_busy, 0);

    // simultaneous issue and write-back on r6 holds the counter at 1
    issue_valid = 1'b1; issue_rd = 3'd6; rs2_addr = 3'd6;
    tick();
    wb_packet = {1'b1, 3'd6, 16'h0606};
    #1;
    chk("same_r6_busy_now", rs2_busy, 0);
    tick();
    issue_valid = 1'b0; wb_packet = '0;
    #1;
    chk("same_r6_busy_next", rs2_busy, 1);
    chk("same_r6_data", rs2_data, 16'h0606);
    wb_packet = {1'b1, 3'd6, 16'h0660};
    tick();
    wb_packet = '0;
    #1;
    chk("same_r6_drained", rs2_busy, 0);

    // register 0 behaviour
    issue_valid = 1'b1; issue_rd = 3'd0; rs1_addr = 3'd0;
    tick();
    issue_valid = 1'b0; wb_packet = {1'b1, 3'd0, 16'hFFFF};
    #1;
`ifdef R0_ZERO_EN
    chk("r0_bypass_blocked", rs1_data, 16'h0000);
    chk("r0_busy", rs1_busy, 0);
    tick();
    wb_packet = '0;
    #1;
    chk("r0_stored", rs1_data, 16'h0000);
    chk("r0_busy_after", rs1_busy, 0);
`else
    chk("r0_bypass", rs1_data, 16'hFFFF);
    chk("r0_busy", rs1_busy, 0);
    tick();
    wb_packet = '0;
    #1;
    chk("r0_stored", rs1_data, 16'hFFFF);
    chk("r0_busy_after", rs1_busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
